acondicionador_botones: RTL and testbench



---
 rtl/acondicionador_botones.sv | 154 +++++++++++++++
 tb/tb_acondicionador_botones.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acondicionador_botones.sv
// Push-button conditioner: sync, debounce, one-shot pulse, auto-repeat.
// Feeds the seconds counter; pulses are single-cycle and mutually exclusive.
module acondicionador_botones #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton_aumenta_raw,
  input  logic boton_disminuye_raw,
  output logic boton_aumenta,
  output logic boton_disminuye,
  output logic aumenta_estable,
  output logic disminuye_estable
);

  typedef enum logic [2:0] {
    IDLE,
    ESPERA_PULSA,
    PULSADO,
    REPITE,
    ESPERA_SUELTA
  } estado_t;

  // The state-entry edge counts as the first stable sample, so the
  // terminal count is two below the sample count.
  localparam bit DEB_1 = (DEBOUNCE_CYCLES <= 1);
  localparam int DEB_LIM = DEB_1 ? 0 : DEBOUNCE_CYCLES - 2;
  localparam int HOLD_LIM = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int REP_LIM = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] C_DEB  = CNT_W'(DEB_LIM);
  localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(HOLD_LIM);
  localparam logic [CNT_W-1:0] C_REP  = CNT_W'(REP_LIM);
  localparam logic [CNT_W-1:0] C_UNO  = CNT_W'(1);

  // Index 0 is the increase button, index 1 the decrease button.
  logic [1:0]       w_raw;
  logic [1:0]       r_s0;
  logic [1:0]       r_sinc;
  logic [1:0]       r_req;
  logic [1:0]       r_est;
  estado_t          r_estado [2];
  logic [CNT_W-1:0] r_cnt    [2];

  assign w_raw = {boton_disminuye_raw, boton_aumenta_raw};

  // Two-flop synchroniser for both raw buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0   <= '0;
      r_sinc <= '0;
    end else begin
      r_s0   <= w_raw;
      r_sinc <= r_s0;
    end
  end

  // Per-button debounce / hold / repeat FSMs with registered requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= '0;
      r_est <= '0;
      for (int i = 0; i < 2; i++) begin
        r_estado[i] <= IDLE;
        r_cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_req[i] <= 1'b0;
        unique case (r_estado[i])
          IDLE: begin
            r_cnt[i] <= '0;
            if (r_sinc[i]) begin
              if (DEB_1) begin
                r_req[i]    <= 1'b1;
                r_est[i]    <= 1'b1;
                r_estado[i] <= PULSADO;
              end else begin
                r_estado[i] <= ESPERA_PULSA;
              end
            end
          end
          ESPERA_PULSA: begin
            if (!r_sinc[i]) begin
              r_cnt[i]    <= '0;
              r_estado[i] <= IDLE;
            end else if (r_cnt[i] == C_DEB) begin
              r_req[i]    <= 1'b1;
              r_est[i]    <= 1'b1;
              r_cnt[i]    <= '0;
              r_estado[i] <= PULSADO;
            end else begin
              r_cnt[i] <= r_cnt[i] + C_UNO;
            end
          end
          PULSADO, REPITE: begin
            if (!r_sinc[i]) begin
              r_cnt[i] <= '0;
              if (DEB_1) begin
                r_est[i]    <= 1'b0;
                r_estado[i] <= IDLE;
              end else begin
                r_estado[i] <= ESPERA_SUELTA;
              end
            end else if (r_cnt[i] ==
                         ((r_estado[i] == PULSADO) ?
                          C_HOLD : C_REP)) begin
              r_req[i]    <= 1'b1;
              r_cnt[i]    <= '0;
              r_estado[i] <= REPITE;
            end else begin
              r_cnt[i] <= r_cnt[i] + C_UNO;
            end
          end
          ESPERA_SUELTA: begin
            if (r_sinc[i]) begin
              r_cnt[i]    <= '0;
              r_estado[i] <= PULSADO;
            end else if (r_cnt[i] == C_DEB) begin
              r_est[i]    <= 1'b0;
              r_cnt[i]    <= '0;
              r_estado[i] <= IDLE;
            end else begin
              r_cnt[i] <= r_cnt[i] + C_UNO;
            end
          end
          default: begin
            r_cnt[i]    <= '0;
            r_estado[i] <= IDLE;
          end
        endcase
      end
    end
  end

  // Arbitration: a request passes only when the other button is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boton_aumenta     <= 1'b0;
      boton_disminuye   <= 1'b0;
      aumenta_estable   <= 1'b0;
      disminuye_estable <= 1'b0;
    end else begin
      boton_aumenta     <= r_req[0] & ~r_req[1] & ~r_est[1];
      boton_disminuye   <= r_req[1] & ~r_req[0] & ~r_est[0];
      aumenta_estable   <= r_est[0];
      disminuye_estable <= r_est[1];
    end
  end

endmodule

// File: tb/tb_acondicionador_botones.sv
// Randomised and directed bench for acondicionador_botones.
// Reference model works on run lengths and hold age, not FSM states.
module tb_acondicionador_botones;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic boton_aumenta;
  logic boton_disminuye;
  logic aumenta_estable;
  logic disminuye_estable;

  int checks = 0;
  int errors = 0;

  logic [1:0] m_d1, m_d2, m_req, m_l;
  int         m_hi [2];
  int         m_lo [2];
  int         m_age[2];
  logic [3:0] exp_vec;
  logic [3:0] got;

  acondicionador_botones #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .boton_aumenta_raw(raw_a),
    .boton_disminuye_raw(raw_b),
    .boton_aumenta(boton_aumenta),
    .boton_disminuye(boton_disminuye),
    .aumenta_estable(aumenta_estable),
    .disminuye_estable(disminuye_estable)
  );

  always #5 clk = ~clk;

  assign got = {boton_aumenta, boton_disminuye,
                aumenta_estable, disminuye_estable};

  // One rising edge of the behavioural model.
  task automatic model_edge();
    logic [1:0] raw;
    logic x;
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_req = '0; m_l = '0;
      for (int j = 0; j < 2; j++) begin
        m_hi[j] = 0; m_lo[j] = 0; m_age[j] = 0;
      end
      exp_vec = '0;
      return;
    end
    exp_vec = {m_req[0] & ~m_req[1] & ~m_l[1],
               m_req[1] & ~m_req[0] & ~m_l[0],
               m_l[0], m_l[1]};
    raw = {raw_b, raw_a};
    for (int j = 0; j < 2; j++) begin
      x = m_d2[j];
      m_d2[j] = m_d1[j];
      m_d1[j] = raw[j];
      if (x) begin
        m_hi[j]++; m_lo[j] = 0;
      end else begin
        m_lo[j]++; m_hi[j] = 0;
      end
      m_req[j] = 1'b0;
      if (!m_l[j]) begin
        if (x && m_hi[j] == DEB) begin
          m_l[j] = 1'b1; m_req[j] = 1'b1; m_age[j] = 0;
        end
      end else if (!x) begin
        if (m_lo[j] == DEB) m_l[j] = 1'b0;
      end else if (m_hi[j] == 1) begin
        m_age[j] = 0;
      end else begin
        m_age[j]++;
        if (m_age[j] == HOLD ||
            (m_age[j] > HOLD && (m_age[j] - HOLD) % REP == 0))
          m_req[j] = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic a, input logic b);
    raw_a = a;
    raw_b = b;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(i[0], i[1]);
      checks++;
      if (got !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got %b want 0000", i, got);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release got %b want 0000", got);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (got !== exp_vec || got !== 4'b0000) begin
        errors++;
        $display("FAIL reset_after cyc %0d got %b want 0000", i, got);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [63:0] pa, pb, ea;
    pa = '0; pb = '0; ea = '0;
    for (int i = 0; i < 20; i++) begin
      tick(i <= 8, 1'b0);
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL clean cyc %0d got %b want %b", i, got, exp_vec);
      end
      pa[i] = boton_aumenta; pb[i] = boton_disminuye;
      ea[i] = aumenta_estable;
    end
    checks += 3;
    if (pa !== 64'h40) begin
      errors++; $display("FAIL clean_pulse got %h want 40", pa);
    end
    if (pb !== 64'h0) begin
      errors++; $display("FAIL clean_dis got %h want 0", pb);
    end
    if (ea !== 64'h7fc0) begin
      errors++; $display("FAIL clean_est got %h want 7fc0", ea);
    end
  endtask

  task automatic test_bounce();
    logic [63:0] pa, ea;
    logic r;
    pa = '0; ea = '0;
    for (int i = 0; i < 30; i++) begin
      r = (i < 4) ? (i % 2 == 0) : (i <= 11);
      tick(r, 1'b0);
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL bounce cyc %0d got %b want %b", i, got, exp_vec);
      end
      pa[i] = boton_aumenta; ea[i] = aumenta_estable;
    end
    checks += 2;
    if (pa !== 64'h400) begin
      errors++; $display("FAIL bounce_pulse got %h want 400", pa);
    end
    if (ea !== 64'h3fc00) begin
      errors++; $display("FAIL bounce_est got %h want 3fc00", ea);
    end
  endtask

  task automatic test_glitch();
    logic [63:0] pa, ea;
    logic r;
    pa = '0; ea = '0;
    for (int i = 0; i < 20; i++) begin
      tick(i < 3, 1'b0);
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL glitch cyc %0d got %b want %b", i, got, exp_vec);
      end
      pa[i] = boton_aumenta; ea[i] = aumenta_estable;
    end
    checks += 2;
    if (pa !== 64'h0 || ea !== 64'h0) begin
      errors++; $display("FAIL glitch_hi got %h/%h want 0/0", pa, ea);
    end
    pa = '0; ea = '0;
    for (int i = 0; i < 30; i++) begin
      r = (i <= 14) && !(i >= 9 && i <= 11);
      tick(r, 1'b0);
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL dip cyc %0d got %b want %b", i, got, exp_vec);
      end
      pa[i] = boton_aumenta; ea[i] = aumenta_estable;
    end
    if (pa !== 64'h40 || ea !== 64'h1fffc0) begin
      errors++;
      $display("FAIL dip_mask got %h/%h want 40/1fffc0", pa, ea);
    end
  endtask

  task automatic test_hold();
    logic [63:0] pa, ea;
    pa = '0; ea = '0;
    for (int i = 0; i < 40; i++) begin
      tick(i <= 29, 1'b0);
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL hold cyc %0d got %b want %b", i, got, exp_vec);
      end
      pa[i] = boton_aumenta; ea[i] = aumenta_estable;
    end
    checks += 2;
    if (pa !== 64'h92490040) begin
      errors++; $display("FAIL hold_pulses got %h want 92490040", pa);
    end
    if (ea !== 64'hfffffffc0) begin
      errors++; $display("FAIL hold_est got %h want fffffffc0", ea);
    end
  endtask

  task automatic test_both();
    logic [63:0] pp, ea, eb;
    pp = '0; ea = '0; eb = '0;
    for (int i = 0; i < 40; i++) begin
      tick(i <= 29, i <= 29);
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL both cyc %0d got %b want %b", i, got, exp_vec);
      end
      pp[i] = boton_aumenta | boton_disminuye;
      ea[i] = aumenta_estable; eb[i] = disminuye_estable;
    end
    checks += 2;
    if (pp !== 64'h0) begin
      errors++; $display("FAIL both_pulses got %h want 0", pp);
    end
    if (ea !== 64'hfffffffc0 || eb !== 64'hfffffffc0) begin
      errors++;
      $display("FAIL both_est got %h/%h want fffffffc0", ea, eb);
    end
  endtask

  task automatic test_reset_repeat();
    logic [63:0] pb;
    pb = '0;
    for (int i = 0; i <= 20; i++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL pre_rst cyc %0d got %b want %b", i, got, exp_vec);
      end
      pb[i] = boton_disminuye;
    end
    checks++;
    if (pb !== 64'h90040 || disminuye_estable !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_mask got %h want 90040", pb);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (got !== 4'b0000) begin
      errors++; $display("FAIL rst_immediate got %b want 0000", got);
    end
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    rst_n = 1'b1;
    #1;
    checks++;
    if (got !== 4'b0000) begin
      errors++; $display("FAIL rst_first got %b want 0000", got);
    end
    pb = '0;
    for (int i = 0; i < 22; i++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL post_rst cyc %0d got %b want %b", i, got, exp_vec);
      end
      pb[i] = boton_disminuye;
    end
    checks++;
    if (pb !== 64'h90040) begin
      errors++; $display("FAIL post_rst_mask got %h want 90040", pb);
    end
  endtask

  task automatic test_random();
    logic a, b, pa, pbp;
    a = 1'b0; b = 1'b0; pa = 1'b0; pbp = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) a = ~a;
      if ($urandom_range(0, 9) == 0) b = ~b;
      tick(a, b);
      checks++;
      if (got !== exp_vec) begin
        errors++;
        $display("FAIL random cyc %0d got %b want %b", i, got, exp_vec);
      end
      checks++;
      if ((boton_aumenta & (boton_disminuye | pa)) ||
          (boton_disminuye & pbp)) begin
        errors++;
        $display("FAIL random_shape cyc %0d got %b%b want no overlap",
                 i, boton_aumenta, boton_disminuye);
      end
      pa = boton_aumenta; pbp = boton_disminuye;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    settle();
    test_bounce();
    settle();
    test_glitch();
    settle();
    test_hold();
    settle();
    test_both();
    settle();
    test_reset_repeat();
    settle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
